// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for the fetch->decode pipeline stage: state encodings and
// the bubble instruction encoding.
package pipe_stage_skid_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_MAIN  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Bubble encoding; instances narrower than 32 bits take the low bits.
  localparam logic [31:0] INVALID_INSTRUCTION = 32'hFFFF_FFFF;

  function automatic logic [1:0] occ_of(input logic [1:0] st);
    logic [1:0] occ;
    occ = 2'd0;
    case (st)
      ST_MAIN: occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// PC + instruction holding register with synchronous load and clear; resets
// and clears to the bubble value {0, INVALID_INSTR}.
module pipe_entry_reg
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned            PC_W          = 16,
  parameter int unsigned            INSTR_W       = 16,
  parameter logic [INSTR_W-1:0]     INVALID_INSTR = INVALID_INSTRUCTION[INSTR_W-1:0]
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;

  // Clear wins over load so a flush can never leave a stale entry behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      instr_q <= INVALID_INSTR;
    end else if (clear_i) begin
      pc_q    <= '0;
      instr_q <= INVALID_INSTR;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Fetch->decode pipeline stage with optional two-entry skid buffer so that
// in_ready can be registered (no combinational path from out_ready).
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned        PC_W          = 16,
  parameter int unsigned        INSTR_W       = 16,
  parameter logic [INSTR_W-1:0] INVALID_INSTR = INVALID_INSTRUCTION[INSTR_W-1:0],
  parameter int unsigned        SKID_EN       = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic [1:0]         occupancy
);

  logic [1:0]         state_q, state_d;
  logic [1:0]         occupancy_q;
  logic               accept, consume;
  logic               main_load, main_clr, main_from_skid;
  logic               skid_load, skid_clr;
  logic [PC_W-1:0]    main_pc, skid_pc, main_pc_d;
  logic [INSTR_W-1:0] main_instr, skid_instr, main_instr_d;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_MAIN;
            main_load = 1'b1;
          end
        end
        ST_MAIN: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            // Only reachable with the skid present: without it in_ready
            // follows out_ready, so an accept in MAIN always pairs with a consume.
            if (SKID_EN != 0) begin
              state_d   = ST_FULL;
              skid_load = 1'b1;
            end
          end else if (consume) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d        = ST_MAIN;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      occupancy_q <= occ_of(state_d);
    end
  end

  assign occupancy = occupancy_q;

  generate
    if (SKID_EN != 0) begin : g_reg_ready
      logic in_ready_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) in_ready_q <= 1'b1;
        else          in_ready_q <= (state_d != ST_FULL);
      end
      assign in_ready = in_ready_q;
    end else begin : g_comb_ready
      assign in_ready = (state_q == ST_EMPTY) | out_ready;
    end
  endgenerate

  assign main_pc_d    = main_from_skid ? skid_pc    : in_pc;
  assign main_instr_d = main_from_skid ? skid_instr : in_instr;

  pipe_entry_reg #(
    .PC_W          (PC_W),
    .INSTR_W       (INSTR_W),
    .INVALID_INSTR (INVALID_INSTR)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (main_load),
    .clear_i (main_clr),
    .pc_i    (main_pc_d),
    .instr_i (main_instr_d),
    .pc_o    (main_pc),
    .instr_o (main_instr)
  );

  generate
    if (SKID_EN != 0) begin : g_skid
      pipe_entry_reg #(
        .PC_W          (PC_W),
        .INSTR_W       (INSTR_W),
        .INVALID_INSTR (INVALID_INSTR)
      ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .pc_i    (in_pc),
        .instr_i (in_instr),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
      );
    end else begin : g_no_skid
      assign skid_pc    = '0;
      assign skid_instr = INVALID_INSTR;
    end
  endgenerate

  // Bubble values are forced whenever nothing is held.
  assign out_pc    = out_valid ? main_pc    : '0;
  assign out_instr = out_valid ? main_instr : INVALID_INSTR;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed-vector and scoreboard bench for pipe_stage_skid (32-bit skid
// instance plus a 16-bit instance without skid).
module tb_pipe_stage_skid;

  localparam logic [31:0] INV   = 32'hFFFF_FFFF;
  localparam logic [15:0] INV16 = 16'hFFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance with skid
  logic        fl, iv, ordy;
  logic [31:0] ipc, iinstr;
  logic        rdy, ov;
  logic [31:0] opc, oinstr;
  logic [1:0]  occ;

  // 16-bit instance without skid
  logic        s_fl, s_iv, s_or;
  logic [15:0] s_pc, s_instr;
  logic        s_rdy, s_ov;
  logic [15:0] s_opc, s_oinstr;
  logic [1:0]  s_occ;

  pipe_stage_skid #(.PC_W(32), .INSTR_W(32), .SKID_EN(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(fl), .in_valid(iv), .in_pc(ipc),
    .in_instr(iinstr), .in_ready(rdy), .out_valid(ov), .out_pc(opc),
    .out_instr(oinstr), .out_ready(ordy), .occupancy(occ)
  );

  pipe_stage_skid #(.PC_W(16), .INSTR_W(16), .SKID_EN(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(s_fl), .in_valid(s_iv), .in_pc(s_pc),
    .in_instr(s_instr), .in_ready(s_rdy), .out_valid(s_ov), .out_pc(s_opc),
    .out_instr(s_oinstr), .out_ready(s_or), .occupancy(s_occ)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic v, input logic [31:0] p,
                       input logic [31:0] ins, input logic r);
    fl = f; iv = v; ipc = p; iinstr = ins; ordy = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        f, v;
    logic [31:0] p, ins;
    logic        r;
    logic        e_ov;
    logic [31:0] e_pc, e_ins;
    logic [1:0]  e_occ;
    logic        e_rdy;
  } vec_t;

  function automatic vec_t mk(logic f, logic v, logic [31:0] p, logic [31:0] ins, logic r,
                              logic e_ov, logic [31:0] e_pc, logic [31:0] e_ins,
                              logic [1:0] e_occ, logic e_rdy);
    vec_t t;
    t.f = f; t.v = v; t.p = p; t.ins = ins; t.r = r;
    t.e_ov = e_ov; t.e_pc = e_pc; t.e_ins = e_ins; t.e_occ = e_occ; t.e_rdy = e_rdy;
    return t;
  endfunction

  vec_t vt[18];
  logic [63:0] mq[$];
  logic        m_rdy;

  initial begin
    // Expected values are the outputs seen just after the edge that applies the vector.
    vt[0]  = mk(0, 1, 32'h00, 32'hA000, 1,  1, 32'h00, 32'hA000, 1, 1);
    vt[1]  = mk(0, 1, 32'h02, 32'hA002, 1,  1, 32'h02, 32'hA002, 1, 1);
    vt[2]  = mk(0, 1, 32'h04, 32'hA004, 1,  1, 32'h04, 32'hA004, 1, 1);
    vt[3]  = mk(0, 0, 32'h06, 32'hA006, 1,  0, 32'h00, INV,      0, 1);
    vt[4]  = mk(0, 1, 32'h10, 32'hB010, 0,  1, 32'h10, 32'hB010, 1, 1);
    vt[5]  = mk(0, 1, 32'h12, 32'hB012, 0,  1, 32'h10, 32'hB010, 2, 0);
    vt[6]  = mk(0, 1, 32'h14, 32'hB014, 0,  1, 32'h10, 32'hB010, 2, 0);
    vt[7]  = mk(0, 1, 32'h16, 32'hB016, 1,  1, 32'h12, 32'hB012, 1, 1);
    vt[8]  = mk(0, 0, 32'h00, 32'h0000, 1,  0, 32'h00, INV,      0, 1);
    vt[9]  = mk(0, 1, 32'h20, 32'hC020, 0,  1, 32'h20, 32'hC020, 1, 1);
    vt[10] = mk(0, 1, 32'h22, 32'hC022, 0,  1, 32'h20, 32'hC020, 2, 0);
    vt[11] = mk(1, 1, 32'h24, 32'hC024, 1,  0, 32'h00, INV,      0, 1);
    vt[12] = mk(0, 0, 32'h00, 32'h0000, 1,  0, 32'h00, INV,      0, 1);
    vt[13] = mk(0, 1, 32'h30, 32'hD030, 1,  1, 32'h30, 32'hD030, 1, 1);
    vt[14] = mk(1, 1, 32'h32, 32'hD032, 1,  0, 32'h00, INV,      0, 1);
    vt[15] = mk(0, 1, 32'h34, 32'hD034, 1,  1, 32'h34, 32'hD034, 1, 1);
    vt[16] = mk(0, 0, 32'h00, 32'h0000, 0,  1, 32'h34, 32'hD034, 1, 1);
    vt[17] = mk(0, 0, 32'h00, 32'h0000, 1,  0, 32'h00, INV,      0, 1);

    drive(0, 0, 0, 0, 0);
    s_fl = 0; s_iv = 0; s_pc = '0; s_instr = '0; s_or = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", {31'd0, ov}, 32'd0);
    chk("reset.out_pc", opc, 32'd0);
    chk("reset.out_instr", oinstr, INV);
    chk("reset.occupancy", {30'd0, occ}, 32'd0);
    chk("reset.in_ready", {31'd0, rdy}, 32'd1);
    chk("reset0.out_instr", {16'd0, s_oinstr}, {16'd0, INV16});
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].f, vt[i].v, vt[i].p, vt[i].ins, vt[i].r);
      step();
      chk($sformatf("v%0d.out_valid", i), {31'd0, ov}, {31'd0, vt[i].e_ov});
      chk($sformatf("v%0d.out_pc", i), opc, vt[i].e_pc);
      chk($sformatf("v%0d.out_instr", i), oinstr, vt[i].e_ins);
      chk($sformatf("v%0d.occupancy", i), {30'd0, occ}, {30'd0, vt[i].e_occ});
      chk($sformatf("v%0d.in_ready", i), {31'd0, rdy}, {31'd0, vt[i].e_rdy});
    end

    // Asynchronous reset pulsed between edges while FULL.
    drive(0, 1, 32'h50, 32'hE050, 0); step();
    drive(0, 1, 32'h52, 32'hE052, 0); step();
    chk("arst.pre_occupancy", {30'd0, occ}, 32'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'd0, ov}, 32'd0);
    chk("arst.out_pc", opc, 32'd0);
    chk("arst.out_instr", oinstr, INV);
    chk("arst.occupancy", {30'd0, occ}, 32'd0);
    chk("arst.in_ready", {31'd0, rdy}, 32'd1);
    #1 reset_n = 1'b1;
    drive(0, 1, 32'h60, 32'hE060, 0); step();
    chk("arst.post_occupancy", {30'd0, occ}, 32'd1);
    chk("arst.post_pc", opc, 32'h60);
    drive(0, 0, 0, 0, 1); step();
    chk("arst.drained", {31'd0, ov}, 32'd0);

    // Single-entry instance: in_ready follows out_ready while MAIN.
    s_iv = 1; s_pc = 16'h0050; s_instr = 16'h5050; s_or = 1; step();
    chk("nsk.load_pc", {16'd0, s_opc}, 32'h50);
    chk("nsk.load_occ", {30'd0, s_occ}, 32'd1);
    s_iv = 0; s_or = 1; #1;
    chk("nsk.rdy_or1", {31'd0, s_rdy}, 32'd1);
    s_or = 0; #1;
    chk("nsk.rdy_or0", {31'd0, s_rdy}, 32'd0);
    s_iv = 1; s_pc = 16'h0052; s_instr = 16'h5052; step();
    chk("nsk.stall_pc", {16'd0, s_opc}, 32'h50);
    chk("nsk.stall_occ", {30'd0, s_occ}, 32'd1);
    s_or = 1; #1;
    chk("nsk.rdy_or1b", {31'd0, s_rdy}, 32'd1);
    step();
    chk("nsk.pass_pc", {16'd0, s_opc}, 32'h52);
    chk("nsk.pass_occ", {30'd0, s_occ}, 32'd1);
    s_iv = 0; step();
    s_or = 0; #1;
    chk("nsk.empty_rdy", {31'd0, s_rdy}, 32'd1);
    chk("nsk.empty_valid", {31'd0, s_ov}, 32'd0);
    chk("nsk.empty_occ", {30'd0, s_occ}, 32'd0);

    // Random valid/ready/flush against a reference queue model.
    drive(0, 0, 0, 0, 0);
    reset_n = 1'b0; #1 reset_n = 1'b1;
    mq.delete();
    m_rdy = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic        f, v, r, acc, cons, e_ov;
      logic [31:0] e_pc, e_ins;
      logic [1:0]  e_occ;
      f = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) == 1);
      drive(f, v, 32'h1000 + 32'(c * 4), $urandom, r);
      acc  = v & m_rdy;
      cons = (mq.size() > 0) & r;
      step();
      if (f) begin
        mq.delete();
      end else begin
        if (cons) void'(mq.pop_front());
        if (acc) mq.push_back({ipc, iinstr});
      end
      m_rdy = (mq.size() < 2);
      e_ov  = (mq.size() > 0);
      e_pc  = e_ov ? mq[0][63:32] : 32'd0;
      e_ins = e_ov ? mq[0][31:0]  : INV;
      e_occ = 2'(mq.size());
      checks++;
      if (ov !== e_ov || opc !== e_pc || oinstr !== e_ins || occ !== e_occ || rdy !== m_rdy) begin
        failures++;
        $display("FAIL rand[%0d] actual v=%b pc=%h in=%h occ=%0d rdy=%b required v=%b pc=%h in=%h occ=%0d rdy=%b",
                 c, ov, opc, oinstr, occ, rdy, e_ov, e_pc, e_ins, e_occ, m_rdy);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
